// File: rtl/reg_bank_sync.sv
// reg_bank_sync: parametrised register bank with two registered read ports
// (A, B), one write port (C), write-first bypass from C to A/B, an optional
// hard-wired zero register and a sequential init engine that gates traffic
// until every register has been loaded after reset.
module reg_bank_sync #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  aData,
    output logic [WIDTH-1:0]  bData,
    input  logic [ADDR_W-1:0] c,
    input  logic [WIDTH-1:0]  cData,
    input  logic              write,
    output logic              ready
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // One bit wider than an address so DEPTH itself is representable.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  init_val;
    logic              wr_acc;
    logic [WIDTH-1:0]  rd_a;
    logic [WIDTH-1:0]  rd_b;

    logic [WIDTH-1:0]  regs [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] x);
        return ({1'b0, x} < DEPTH_X);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] x);
        return (ZERO_REG != 0) && (x == '0);
    endfunction

    // Read value seen by a port: out-of-range and the zero register read 0,
    // an accepted same-edge write is forwarded, otherwise the stored value.
    function automatic logic [WIDTH-1:0] rdval(input logic [ADDR_W-1:0] x);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!in_range(x)) begin
            v = '0;
        end else if (is_zero_reg(x)) begin
            v = '0;
        end else if (wr_acc && (c == x)) begin
            v = cData;
        end else begin
            v = regs[x];
        end
        return v;
    endfunction

    // State register and init counter; counter parks at the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if ((state == INIT) && (cnt != LAST)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state: leave INIT on the edge that loads the last register.
    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (cnt == LAST) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = INIT;
        endcase
    end

    // Outputs and qualifiers derived from the current state.
    always_comb begin
        ready    = (state == READY);
        // Register 0 is loaded with cnt==0, i.e. 0, so ZERO_REG needs no special case here.
        init_val = '0;
        if (INIT_INDEX != 0) begin
            init_val = WIDTH'(cnt);
        end
        wr_acc = (state == READY) && write && in_range(c) && !is_zero_reg(c);
        rd_a   = rdval(a);
        rd_b   = rdval(b);
    end

    // Storage array: init engine during INIT, port C once READY.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[cnt] <= init_val;
        end else if (wr_acc) begin
            regs[c] <= cData;
        end
    end

    // Registered read ports: capture only in READY with rd_en, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aData <= '0;
            bData <= '0;
        end else if ((state == READY) && rd_en) begin
            aData <= rd_a;
            bData <= rd_b;
        end
    end

endmodule

// File: tb/tb_reg_bank_sync.sv
// Directed testbench for reg_bank_sync: default instance (32x64, index
// init), a ZERO_REG instance and a 16x8 instance sharing clock and reset.
module tb_reg_bank_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // u0: defaults
    logic [4:0]  a0, b0, c0;
    logic        rd0, wr0;
    logic [63:0] cd0, ad0, bd0;
    logic        rdy0;
    // u1: ZERO_REG=1
    logic [4:0]  a1, b1, c1;
    logic        rd1, wr1;
    logic [63:0] cd1, ad1, bd1;
    logic        rdy1;
    // u2: 16 x 8
    logic [3:0]  a2, b2, c2;
    logic        rd2, wr2;
    logic [7:0]  cd2, ad2, bd2;
    logic        rdy2;

    reg_bank_sync u0 (
        .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .rd_en(rd0),
        .aData(ad0), .bData(bd0), .c(c0), .cData(cd0), .write(wr0), .ready(rdy0)
    );

    reg_bank_sync #(.WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .INIT_INDEX(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .rd_en(rd1),
        .aData(ad1), .bData(bd1), .c(c1), .cData(cd1), .write(wr1), .ready(rdy1)
    );

    reg_bank_sync #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .ZERO_REG(0), .INIT_INDEX(1)) u2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .rd_en(rd2),
        .aData(ad2), .bData(bd2), .c(c2), .cData(cd2), .write(wr2), .ready(rdy2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        write;
        logic [4:0]  c;
        logic [63:0] cdata;
        logic        rd_en;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    function automatic vec_t mk(input string n, input logic w, input logic [4:0] c,
                                input logic [63:0] cd, input logic r, input logic [4:0] a,
                                input logic [4:0] b, input logic [63:0] ea, input logic [63:0] eb);
        vec_t v;
        v.name = n; v.write = w; v.c = c; v.cdata = cd; v.rd_en = r;
        v.a = a; v.b = b; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    vec_t vecs[9];

    task automatic op1(input string n, input logic w, input logic [4:0] c, input logic [63:0] cd,
                       input logic r, input logic [4:0] a, input logic [4:0] b,
                       input logic [63:0] ea, input logic [63:0] eb);
        wr1 = w; c1 = c; cd1 = cd; rd1 = r; a1 = a; b1 = b;
        tick();
        chk({n, "_a"}, ad1, ea);
        chk({n, "_b"}, bd1, eb);
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic op2(input string n, input logic w, input logic [3:0] c, input logic [7:0] cd,
                       input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] ea, input logic [7:0] eb);
        wr2 = w; c2 = c; cd2 = cd; rd2 = r; a2 = a; b2 = b;
        tick();
        chk({n, "_a"}, 64'(ad2), 64'(ea));
        chk({n, "_b"}, 64'(bd2), 64'(eb));
        wr2 = 1'b0; rd2 = 1'b0;
    endtask

    // Counts DEPTH edges after release and checks ready rises on the last one.
    task automatic count_init(input string n);
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk({n, "_rdy0"}, 64'(rdy0), 64'(e == 32));
            chk({n, "_rdy2"}, 64'(rdy2), 64'(e >= 16));
        end
    endtask

    initial begin
        vecs[0] = mk("rd_5_31",     1'b0, 5'd0,  64'h0,        1'b1, 5'd5,  5'd31, 64'd5,        64'd31);
        vecs[1] = mk("bypass_7",    1'b1, 5'd7,  64'hDEADBEEF, 1'b1, 5'd7,  5'd7,  64'hDEADBEEF, 64'hDEADBEEF);
        vecs[2] = mk("rd_7_3",      1'b0, 5'd0,  64'h0,        1'b1, 5'd7,  5'd3,  64'hDEADBEEF, 64'd3);
        vecs[3] = mk("hold",        1'b0, 5'd0,  64'h0,        1'b0, 5'd1,  5'd2,  64'hDEADBEEF, 64'd3);
        vecs[4] = mk("wr0_hold",    1'b1, 5'd0,  64'h1234,     1'b0, 5'd1,  5'd2,  64'hDEADBEEF, 64'd3);
        vecs[5] = mk("rd_0_31",     1'b0, 5'd0,  64'h0,        1'b1, 5'd0,  5'd31, 64'h1234,     64'd31);
        vecs[6] = mk("bypass_b31",  1'b1, 5'd31, 64'hAAAA,     1'b1, 5'd30, 5'd31, 64'd30,       64'hAAAA);
        vecs[7] = mk("rd_31_31",    1'b0, 5'd0,  64'h0,        1'b1, 5'd31, 5'd31, 64'hAAAA,     64'hAAAA);
        vecs[8] = mk("bypass_b5",   1'b1, 5'd5,  64'h77,       1'b1, 5'd6,  5'd5,  64'd6,        64'h77);

        rst_n = 1'b0;
        a0 = '0; b0 = '0; c0 = '0; cd0 = '0; rd0 = 1'b0; wr0 = 1'b0;
        a1 = '0; b1 = '0; c1 = '0; cd1 = '0; rd1 = 1'b0; wr1 = 1'b0;
        a2 = '0; b2 = '0; c2 = '0; cd2 = '0; rd2 = 1'b0; wr2 = 1'b0;
        repeat (3) tick();
        chk("rst_a0", ad0, 64'h0);
        chk("rst_b0", bd0, 64'h0);
        chk("rst_rdy0", 64'(rdy0), 64'h0);
        chk("rst_rdy1", 64'(rdy1), 64'h0);
        chk("rst_rdy2", 64'(rdy2), 64'h0);

        // Traffic during INIT must be ignored.
        wr0 = 1'b1; c0 = 5'd3; cd0 = 64'hFF; rd0 = 1'b1; a0 = 5'd3; b0 = 5'd7;
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk("init_rdy0", 64'(rdy0), 64'(e == 32));
            chk("init_a0", ad0, 64'h0);
            chk("init_b0", bd0, 64'h0);
            chk("init_rdy1", 64'(rdy1), 64'(e == 32));
            chk("init_rdy2", 64'(rdy2), 64'(e >= 16));
        end
        wr0 = 1'b0; rd0 = 1'b0;

        for (int i = 0; i < 9; i++) begin
            wr0 = vecs[i].write; c0 = vecs[i].c; cd0 = vecs[i].cdata;
            rd0 = vecs[i].rd_en; a0 = vecs[i].a; b0 = vecs[i].b;
            tick();
            chk({vecs[i].name, "_a"}, ad0, vecs[i].exp_a);
            chk({vecs[i].name, "_b"}, bd0, vecs[i].exp_b);
        end
        wr0 = 1'b0; rd0 = 1'b0;

        op1("z_init",     1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd1, 64'h0,  64'd1);
        op1("z_bypass",   1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 5'd0, 64'h0,  64'h0);
        op1("z_after",    1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd2, 64'h0,  64'd2);
        op1("z_wr1",      1'b1, 5'd1, 64'h99, 1'b1, 5'd1, 5'd0, 64'h99, 64'h0);

        op2("s_rd_15_2",  1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 4'd2,  8'h0F, 8'h02);
        op2("s_bypass",   1'b1, 4'd15, 8'hA5, 1'b1, 4'd15, 4'd14, 8'hA5, 8'h0E);
        op2("s_rd_15_0",  1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 4'd0,  8'hA5, 8'h00);

        // Asynchronous reset after ready with aData nonzero.
        chk("pre_rst_a0", ad0, 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a0", ad0, 64'h0);
        chk("arst_b0", bd0, 64'h0);
        chk("arst_rdy0", 64'(rdy0), 64'h0);
        chk("arst_a2", 64'(ad2), 64'h0);
        tick();
        rst_n = 1'b1;
        count_init("rel1");

        // Reset pulsed mid-INIT once cnt has reached 10.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("mid_rdy0_pre", 64'(rdy0), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rdy0", 64'(rdy0), 64'h0);
        chk("mid_a0", ad0, 64'h0);
        tick();
        rst_n = 1'b1;
        count_init("rel2");

        // Init rewrote the register previously holding DEADBEEF.
        rd0 = 1'b1; a0 = 5'd7; b0 = 5'd31;
        tick();
        chk("reinit_a0", ad0, 64'd7);
        chk("reinit_b0", bd0, 64'd31);
        rd0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_bank_sync.md
Name: reg_bank_sync

Overview:
- Parametrised successor to the team's 32x64 register bank.
- Two registered read ports (A, B) and one write port (C).
- Configurable width and depth, optional hard-wired zero register.
- Write-first bypass from C to A/B; after every reset, a sequential init engine loads each register and raises `ready` when done.
- Sits between the datapath control and the ALU operand latches.

Parameters:
- WIDTH, 64, data width of every register and data port.
- DEPTH, 32, number of registers; must be >= 2.
- ADDR_W, 5, address width; must equal clog2(DEPTH).
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes.
- INIT_INDEX, 1, 1 = init loads register k with k (zero-extended to WIDTH); 0 = init loads 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  ADDR_W  read address, port A.
- b  input  ADDR_W  read address, port B.
- rd_en  input  1  capture read data on this edge.
- aData  output  WIDTH  registered read data, port A.
- bData  output  WIDTH  registered read data, port B.
- c  input  ADDR_W  write address.
- cData  input  WIDTH  write data.
- write  input  1  write request.
- ready  output  1  init complete; bank accepts traffic.

Behaviour:
- Interface: one clock (`clk`), reset asynchronous, active-low (`rst_n`).
- Reset asserted:
  - Immediately: aData=0, bData=0, ready=0.
  - State=INIT, init counter=0.
  - Register array contents undefined until INIT rewrites them.
- FSM states: INIT, READY. No other states.
- INIT:
  - Each rising edge writes registers[cnt] = (INIT_INDEX ? cnt : 0), then cnt++.
  - The edge that writes cnt==DEPTH-1 also sets ready=1 and moves to READY.
  - First edge after rst_n rises writes reg 0; ready is high after exactly DEPTH edges.
  - With ZERO_REG=1, reg 0 is written 0 regardless of INIT_INDEX.
  - write and rd_en are ignored; aData/bData hold 0.
- READY, write:
  - On an edge with write=1, registers[c] <= cData.
  - Write dropped if c >= DEPTH, or if ZERO_REG=1 and c==0.
- READY, read:
  - On an edge with rd_en=1: aData <= rdval(a) and bData <= rdval(b). Latency is 1 edge.
  - rdval(x) priority:
    - 0 if x >= DEPTH;
    - else 0 if ZERO_REG=1 and x==0;
    - else cData if an accepted write to x occurs on the same edge (write-first bypass);
    - else registers[x].
  - rd_en=0: aData/bData hold their previous values.
  - a==b is legal; both ports return the same value.
- ready stays 1 until the next reset; there is no other path back to INIT.
- Reset mid-INIT or mid-traffic: asynchronously return to the reset state above. INIT restarts from cnt=0; any in-flight write is lost.
- No combinational path from inputs to aData/bData/ready.

Test Plan:
- Release rst_n, hold write=1 with c=3, cData=FF, and rd_en=1 during INIT.
  - Required: ready=0 for 31 edges and rises on edge 32.
  - aData/bData=0 throughout; reg 3 ends at 3, not FF.
- After ready, rd_en=1 with a=5, b=31.
  - Required: next edge aData=5, bData=31 (INIT_INDEX=1).
- Same edge: write=1, c=7, cData=0xDEADBEEF, rd_en=1, a=7, b=7.
  - Required: aData=bData=0xDEADBEEF on that edge (bypass).
  - A later read of 7 returns 0xDEADBEEF.
- ZERO_REG=1 instance: write c=0, cData=0x55, then read a=0.
  - Required: aData=0, with or without bypass.
  - Init also leaves reg 0 at 0.
- DEPTH=16, ADDR_W=4, WIDTH=8 instance: after ready, read a=15, b=2.
  - Required: aData=0x0F, bData=0x02.
- Pulse rst_n low mid-INIT at cnt=10, and separately after ready with aData nonzero.
  - Required: aData/bData/ready drop to 0 without waiting for a clock edge.
  - ready returns exactly DEPTH edges after release.
